// File: rtl/us_icmp_pkg.sv
// us_icmp_pkg: ICMP constants, state encoding and beat-building helpers shared by echo tx/reply.
package us_icmp_pkg;
  localparam logic [7:0] ICMP_TYPE_ECHO_REQ = 8'd8;
  localparam logic [7:0] ICMP_TYPE_ECHO_REPLY = 8'd0;
  localparam bit LANE0_FIRST = 1'b1;
  typedef enum logic [1:0] {IDLE, CALC, FOLD, SEND} icmp_state_t;
  function automatic logic [31:0] sum4(input logic [63:0] d);
    logic [31:0] s;
    s = '0;
    for (int j = 0; j < 4; j++) s += {16'h0, d[16*j +: 8], d[16*j+8 +: 8]};
    return s;
  endfunction
  // first wire byte sits in the MSBs of the packed header and is spread to lanes in wire order
  function automatic logic [63:0] hdr_beat(input logic [7:0] t, input logic [15:0] cs, input logic [15:0] id,
                                           input logic [15:0] sq);
    logic [63:0] b;
    logic [63:0] r;
    b = {t, 8'h00, cs, id, sq};
    r = '0;
    for (int n = 0; n < 8; n++) r[8*(LANE0_FIRST ? n : 7-n) +: 8] = b[8*(7-n) +: 8];
    return r;
  endfunction
  function automatic logic [63:0] payload_chunk(input int unsigned k, input int unsigned p);
    logic [63:0] c;
    logic [31:0] idx;
    c = '0;
    for (int n = 0; n < 8; n++) begin
      idx = k * 8 + n;
      c[8*n +: 8] = idx < p ? idx[7:0] : 8'h00;
    end
    return c;
  endfunction
endpackage

// File: rtl/icmp_csum_acc.sv
// icmp_csum_acc: four-word one's-complement accumulate, double carry fold and complement.
module icmp_csum_acc
  import us_icmp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        add,
  input  logic        fold,
  input  logic [63:0] data,
  output logic [15:0] csum
);
  logic [31:0] acc;
  logic [16:0] s1;
  logic [15:0] s2;
  always_comb begin
    s1 = {1'b0, acc[15:0]} + {1'b0, acc[31:16]};
    s2 = s1[15:0] + {15'h0, s1[16]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      csum <= '0;
    end else begin
      if (add) acc <= (clr ? 32'h0 : acc) + sum4(data);
      if (fold) csum <= ~s2;
    end
  end
endmodule

// File: rtl/us_icmp_echo_tx.sv
// us_icmp_echo_tx: builds one ICMP echo request per ping_req and streams it as 64-bit AXIS beats.
module us_icmp_echo_tx
  import us_icmp_pkg::*;
#(
  parameter int PAYLOAD_BYTES = 32
) (
  input  logic        tx_axis_aclk,
  input  logic        tx_axis_reset,
  input  logic        mac_exist,
  input  logic        ping_req,
  input  logic [15:0] ping_id,
  output logic        ping_busy,
  output logic        ping_done,
  output logic        ping_err,
  output logic [15:0] ping_seq,
  output logic        icmp_req_pending,
  output logic [63:0] icmp_tx_axis_tdata,
  output logic [7:0]  icmp_tx_axis_tkeep,
  output logic        icmp_tx_axis_tvalid,
  output logic        icmp_tx_axis_tlast,
  input  logic        icmp_tx_axis_tready
);
  localparam int CALC_CYC = (PAYLOAD_BYTES + 7) / 8;
  localparam int BEATS = (PAYLOAD_BYTES + 15) / 8;
  localparam int CW = $clog2(BEATS + 1);
  localparam logic [7:0] KEEP_LAST = PAYLOAD_BYTES % 8 == 0 ? 8'hFF : 8'((1 << (PAYLOAD_BYTES % 8)) - 1);
  icmp_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [15:0] id, seq, csum;
  logic [63:0] acc_data;
  logic accept, last, hs, err;
  always_comb begin
    accept = state == IDLE && ping_req && mac_exist;
    last = cnt == CW'(BEATS - 1);
    icmp_tx_axis_tvalid = state == SEND;
    icmp_tx_axis_tlast = icmp_tx_axis_tvalid && last;
    hs = icmp_tx_axis_tvalid && icmp_tx_axis_tready;
    ping_done = hs && last;
    ping_busy = state != IDLE;
    icmp_req_pending = state != IDLE;
    ping_err = err;
    ping_seq = seq;
    icmp_tx_axis_tkeep = !icmp_tx_axis_tvalid ? 8'h00 : last ? KEEP_LAST : 8'hFF;
    icmp_tx_axis_tdata = !icmp_tx_axis_tvalid ? 64'h0 :
                         cnt == '0 ? hdr_beat(ICMP_TYPE_ECHO_REQ, csum, id, seq) :
                         payload_chunk(32'(cnt) - 32'd1, PAYLOAD_BYTES);
    // the header enters the sum with a zero checksum field in the same cycle the request is accepted
    acc_data = state == IDLE ? hdr_beat(ICMP_TYPE_ECHO_REQ, 16'h0, ping_id, seq) :
               payload_chunk(32'(cnt), PAYLOAD_BYTES);
    state_n = state;
    if (accept) state_n = CALC;
    if (state == CALC && cnt == CW'(CALC_CYC - 1)) state_n = FOLD;
    if (state == FOLD) state_n = SEND;
    if (ping_done) state_n = IDLE;
  end
  always_ff @(posedge tx_axis_aclk) begin
    if (tx_axis_reset) begin
      state <= IDLE;
      cnt   <= '0;
      id    <= '0;
      seq   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      err   <= ping_req && !accept;
      if (accept) id <= ping_id;
      if (ping_done) seq <= seq + 16'd1;
      cnt <= state_n != state ? '0 : (state == CALC || hs) ? cnt + 1'b1 : cnt;
    end
  end
  icmp_csum_acc u_csum (
    .clk  (tx_axis_aclk),
    .rst  (tx_axis_reset),
    .clr  (accept),
    .add  (accept || state == CALC),
    .fold (state == FOLD),
    .data (acc_data),
    .csum (csum)
  );
endmodule

// File: tb/tb_us_icmp_echo_tx.sv
// tb_us_icmp_echo_tx: three payload sizes checked against a byte-level ICMP frame model.
module tb_us_icmp_echo_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst[3], mac[3], req[3], rdy[3];
  logic [15:0] pid[3];
  logic busy[3], done[3], err[3], pend[3], tvalid[3], tlast[3];
  logic [15:0] seqo[3];
  logic [63:0] tdata[3];
  logic [7:0] tkeep[3];
  int pbytes[3] = '{8, 13, 32};
  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      us_icmp_echo_tx #(.PAYLOAD_BYTES(g == 0 ? 8 : g == 1 ? 13 : 32)) u_dut (
        .tx_axis_aclk        (clk),
        .tx_axis_reset       (rst[g]),
        .mac_exist           (mac[g]),
        .ping_req            (req[g]),
        .ping_id             (pid[g]),
        .ping_busy           (busy[g]),
        .ping_done           (done[g]),
        .ping_err            (err[g]),
        .ping_seq            (seqo[g]),
        .icmp_req_pending    (pend[g]),
        .icmp_tx_axis_tdata  (tdata[g]),
        .icmp_tx_axis_tkeep  (tkeep[g]),
        .icmp_tx_axis_tvalid (tvalid[g]),
        .icmp_tx_axis_tlast  (tlast[g]),
        .icmp_tx_axis_tready (rdy[g])
      );
    end
  endgenerate
  int total = 0, bad = 0;
  logic [63:0] exp_d[200];
  logic [7:0] exp_k[200];
  int exp_n;
  logic [15:0] exp_seq[3];
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask
  // whole message as a byte list, RFC 1071 checksum over it, then cut into 8-byte beats
  task automatic build(input int p, input logic [15:0] id, input logic [15:0] s);
    logic [7:0] m[1480];
    int len;
    logic [31:0] sum;
    len = 8 + p;
    m[0] = 8'h08; m[1] = 8'h00; m[2] = 8'h00; m[3] = 8'h00;
    m[4] = id[15:8]; m[5] = id[7:0]; m[6] = s[15:8]; m[7] = s[7:0];
    for (int k = 0; k < p; k++) m[8+k] = 8'(k);
    sum = 0;
    for (int k = 0; k < len; k += 2) sum += {16'h0, m[k], (k + 1 < len) ? m[k+1] : 8'h00};
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
    m[2] = ~sum[15:8];
    m[3] = ~sum[7:0];
    exp_n = (len + 7) / 8;
    for (int b = 0; b < exp_n; b++) begin
      exp_d[b] = '0;
      exp_k[b] = '0;
      for (int l = 0; l < 8; l++)
        if (8 * b + l < len) begin
          exp_d[b][8*l +: 8] = m[8*b+l];
          exp_k[b][l] = 1'b1;
        end
    end
  endtask
  task automatic run_pkt(input int i, input logic [15:0] id, input int mode, input bit inject,
                         output logic [63:0] first, output int nb, output logic [7:0] lk);
    int cyc;
    bit fin, stall;
    logic [63:0] hd;
    logic [7:0] hk;
    logic hl;
    logic [15:0] nxt;
    build(pbytes[i], id, exp_seq[i]);
    first = '0; nb = 0; lk = '0; fin = 0; stall = 0; hd = '0; hk = '0; hl = 1'b0;
    @(negedge clk);
    mac[i] = 1'b1; req[i] = 1'b1; pid[i] = id;
    @(negedge clk);
    req[i] = 1'b0;
    mac[i] = 1'($urandom % 2);
    chk("busy_pending", 64'({busy[i], pend[i]}), 64'b11);
    cyc = 1;
    while (!tvalid[i] && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", 64'(cyc), 64'((pbytes[i] + 7) / 8 + 2));
    for (int t = 0; t < 1000 && !fin; t++) begin
      rdy[i] = mode == 0 ? 1'b1 : mode == 1 ? 1'(t % 2 == 0) : 1'($urandom % 2);
      if (inject && t == 0) req[i] = 1'b1;
      if (inject && t == 1) begin
        req[i] = 1'b0;
        chk("err_in_send", 64'(err[i]), 64'd1);
      end
      #1;
      chk("tvalid_cont", 64'(tvalid[i]), 64'd1);
      if (stall) begin
        chk("stall_data", tdata[i], hd);
        chk("stall_ctl", 64'({tlast[i], tkeep[i]}), 64'({hl, hk}));
      end
      if (rdy[i]) begin
        if (nb == 0) first = tdata[i];
        if (nb < exp_n) begin
          chk("beat_data", tdata[i], exp_d[nb]);
          chk("beat_keep", 64'(tkeep[i]), 64'(exp_k[nb]));
        end
        chk("tlast_pos", 64'(tlast[i]), 64'(nb == exp_n - 1));
        chk("done_pulse", 64'(done[i]), 64'(nb == exp_n - 1));
        lk = tkeep[i];
        nb++;
        if (tlast[i] || nb >= exp_n) fin = 1;
      end else begin
        hd = tdata[i]; hk = tkeep[i]; hl = tlast[i];
      end
      stall = !rdy[i];
      @(negedge clk);
    end
    chk("finished", 64'(fin), 64'd1);
    chk("beats", 64'(nb), 64'(exp_n));
    nxt = exp_seq[i] + 16'd1;
    chk("seq_next", 64'(seqo[i]), 64'(nxt));
    chk("idle_after", 64'({busy[i], tvalid[i], done[i]}), 64'd0);
    exp_seq[i] = nxt;
  endtask
  typedef struct {
    int inst;
    logic [15:0] id;
    int mode;
    bit inject;
    int beats;
    logic [7:0] keep;
    logic [15:0] csum;
  } vec_t;
  vec_t tbl[3];
  initial begin
    logic [63:0] first;
    int nb, cyc, hs;
    logic [7:0] lk;
    bit seen;
    tbl[0] = '{0, 16'h1234, 0, 1'b0, 2, 8'hFF, 16'hD9BB};
    tbl[1] = '{1, 16'hBEEF, 1, 1'b1, 3, 8'h1F, 16'h0EEC};
    tbl[2] = '{2, 16'h0001, 0, 1'b0, 5, 8'hFF, 16'h06FE};
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; mac[i] = 1'b0; req[i] = 1'b0; rdy[i] = 1'b0; pid[i] = '0; exp_seq[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_data", tdata[i], 64'h0);
      chk("rst_ctl", 64'({seqo[i], tkeep[i], tvalid[i], tlast[i], busy[i], done[i], err[i], pend[i]}), 64'h0);
      rst[i] = 1'b0;
    end
    for (int r = 0; r < 3; r++) begin
      run_pkt(tbl[r].inst, tbl[r].id, tbl[r].mode, tbl[r].inject, first, nb, lk);
      chk("tbl_beats", 64'(nb), 64'(tbl[r].beats));
      chk("tbl_keep", 64'(lk), 64'(tbl[r].keep));
      chk("tbl_csum", 64'({first[23:16], first[31:24]}), 64'(tbl[r].csum));
    end
    // request without a resolved MAC is refused
    @(negedge clk);
    mac[0] = 1'b0; req[0] = 1'b1; pid[0] = 16'h5555;
    @(negedge clk);
    req[0] = 1'b0;
    chk("err_nomac", 64'(err[0]), 64'd1);
    chk("busy_nomac", 64'(busy[0]), 64'd0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      seen |= tvalid[0] | busy[0];
    end
    chk("no_tx_nomac", 64'(seen), 64'd0);
    chk("seq_nomac", 64'(seqo[0]), 64'(exp_seq[0]));
    // sequence wrap
    @(negedge clk);
    force g_dut[0].u_dut.seq = 16'hFFFF;
    @(negedge clk);
    release g_dut[0].u_dut.seq;
    exp_seq[0] = 16'hFFFF;
    chk("seq_forced", 64'(seqo[0]), 64'hFFFF);
    run_pkt(0, 16'hA5A5, 2, 1'b0, first, nb, lk);
    chk("wrap_lanes", 64'({first[55:48], first[63:56]}), 64'hFFFF);
    // reset during beat 2 of the 32-byte packet
    @(negedge clk);
    mac[2] = 1'b1; req[2] = 1'b1; pid[2] = 16'h7777; rdy[2] = 1'b1;
    @(negedge clk);
    req[2] = 1'b0;
    cyc = 0;
    while (!tvalid[2] && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    hs = 0;
    while (hs < 2 && cyc < 300) begin
      if (tvalid[2] && rdy[2]) hs++;
      @(negedge clk);
      cyc++;
    end
    chk("beat2_valid", 64'(tvalid[2]), 64'd1);
    rst[2] = 1'b1;
    #1;
    chk("no_done_rst", 64'(done[2]), 64'd0);
    @(negedge clk);
    chk("rst_drop", 64'({tvalid[2], tlast[2], done[2], busy[2]}), 64'd0);
    chk("rst_seq", 64'(seqo[2]), 64'd0);
    @(negedge clk);
    rst[2] = 1'b0;
    exp_seq[2] = '0;
    run_pkt(2, 16'hCAFE, 0, 1'b0, first, nb, lk);
    chk("seq_after_rst", 64'({first[55:48], first[63:56]}), 64'd0);
    repeat (15) begin
      int i;
      i = int'($urandom % 3);
      run_pkt(i, 16'($urandom), 2, 1'($urandom % 2), first, nb, lk);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
